// File: rtl/signal_spi_master.sv
// signal_spi_master
// Sends one 48-bit frame, built from six signal bytes, over SPI mode 0
// (CPOL=0, CPHA=0), MSB first.
// Each frame has a setup phase, then 48 sck high/low pairs, then a hold phase.
// Every phase lasts CLK_DIV clk cycles. All outputs come straight from flops.
//
// Ports
//   clk       : system clock; all logic runs on its rising edge
//   reset     : synchronous, active-high reset
//   start     : request one frame; only honoured while idle
//   sd0..sd5  : signal bytes; sd0 is the frame MSB byte, sd5 the LSB byte
//   busy      : high from frame acceptance until frame end
//   done      : one-cycle pulse at frame end
//   sck       : SPI clock, idles low
//   sdo       : SPI data out; changes on the falling sck edge
//   cs_n      : active-low chip select
module signal_spi_master #(
  parameter int CLK_DIV    = 12,
  parameter int FRAME_BITS = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] sd0,
  input  logic [7:0] sd1,
  input  logic [7:0] sd2,
  input  logic [7:0] sd3,
  input  logic [7:0] sd4,
  input  logic [7:0] sd5,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       sdo,
  output logic       cs_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // The divider counts down to zero and is reloaded on every phase change.
  // With CLK_DIV=1 the reload value is 0, so every phase lasts one cycle.
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT   = 6'(FRAME_BITS);

  state_t                r_state;
  logic [7:0]            r_div;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_bit;
  logic                  r_sck;
  logic                  r_sdo;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [7:0]            w_div_nxt;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [5:0]            w_bit_nxt;
  logic                  w_sck_nxt;
  logic                  w_sdo_nxt;
  logic                  w_cs_n_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_div_zero;

  assign w_div_zero = (r_div == 8'd0);

  // Next-state logic and next values for the registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_sck_nxt   = r_sck;
    w_sdo_nxt   = r_sdo;
    w_cs_n_nxt  = r_cs_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          // Latch the frame now, so later sdN changes cannot reach it
          w_shift_nxt = {sd0, sd1, sd2, sd3, sd4, sd5};
          w_sdo_nxt   = sd0[7];
          w_sck_nxt   = 1'b0;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_bit_nxt   = 6'd0;
          w_div_nxt   = DIV_RELOAD;
          w_state_nxt = SETUP;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      SETUP: begin
        if (w_div_zero) begin
          w_sck_nxt   = 1'b1;
          w_div_nxt   = DIV_RELOAD;
          w_state_nxt = SHIFT_HI;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      SHIFT_HI: begin
        if (w_div_zero) begin
          // Falling sck edge: present the next bit
          w_sck_nxt   = 1'b0;
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
          w_sdo_nxt   = r_shift[FRAME_BITS-2];
          w_bit_nxt   = r_bit + 6'd1;
          w_div_nxt   = DIV_RELOAD;
          w_state_nxt = SHIFT_LO;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      SHIFT_LO: begin
        if (w_div_zero) begin
          w_div_nxt = DIV_RELOAD;
          if (r_bit >= LAST_BIT) begin
            w_sdo_nxt   = 1'b0;
            w_state_nxt = HOLD;
          end else begin
            w_sck_nxt   = 1'b1;
            w_state_nxt = SHIFT_HI;
          end
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      HOLD: begin
        if (w_div_zero) begin
          w_cs_n_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_sck_nxt   = 1'b0;
          w_sdo_nxt   = 1'b0;
          w_div_nxt   = 8'd0;
          w_state_nxt = IDLE;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      default: begin
        w_cs_n_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_sck_nxt   = 1'b0;
        w_sdo_nxt   = 1'b0;
        w_div_nxt   = 8'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset takes priority over start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_shift <= '0;
      r_bit   <= 6'd0;
      r_sck   <= 1'b0;
      r_sdo   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_sck   <= w_sck_nxt;
      r_sdo   <= w_sdo_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sck  = r_sck;
  assign sdo  = r_sdo;
  assign cs_n = r_cs_n;

endmodule

// File: tb/tb_signal_spi_master.sv
// Directed bench for signal_spi_master.
// Two instances share the same inputs: CLK_DIV=2 and CLK_DIV=1.
// A small slave model samples sdo on every rising sck edge of the
// instance that is currently selected.
module tb_signal_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] sd0, sd1, sd2, sd3, sd4, sd5;

  logic busy_2, done_2, sck_2, sdo_2, cs_n_2;
  logic busy_1, done_1, sck_1, sdo_1, cs_n_1;

  logic sel1;
  logic m_busy, m_done, m_sck, m_sdo, m_cs_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [47:0] cap;
  int          low, rises, dones, bad, ones_hi, idle_bad;
  bit          got_done;

  always #5 clk = ~clk;

  signal_spi_master #(.CLK_DIV(2), .FRAME_BITS(48)) u_dut2 (
    .clk(clk), .reset(reset), .start(start),
    .sd0(sd0), .sd1(sd1), .sd2(sd2), .sd3(sd3), .sd4(sd4), .sd5(sd5),
    .busy(busy_2), .done(done_2), .sck(sck_2), .sdo(sdo_2), .cs_n(cs_n_2)
  );

  signal_spi_master #(.CLK_DIV(1), .FRAME_BITS(48)) u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .sd0(sd0), .sd1(sd1), .sd2(sd2), .sd3(sd3), .sd4(sd4), .sd5(sd5),
    .busy(busy_1), .done(done_1), .sck(sck_1), .sdo(sdo_1), .cs_n(cs_n_1)
  );

  assign m_busy = sel1 ? busy_1 : busy_2;
  assign m_done = sel1 ? done_1 : done_2;
  assign m_sck  = sel1 ? sck_1  : sck_2;
  assign m_sdo  = sel1 ? sdo_1  : sdo_2;
  assign m_cs_n = sel1 ? cs_n_1 : cs_n_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: watches the selected instance from the current sample on.
  // It stops at done, at rise number stop_rise, or when max_cyc runs out.
  // At rise number disturb_rise it pulses start and changes sd0.
  task automatic watch(input int max_cyc, input int disturb_rise, input int stop_rise,
                       output logic [47:0] o_cap, output int o_low, output int o_rises,
                       output int o_dones, output int o_bad, output int o_ones_hi,
                       output bit o_got);
    logic prev;
    bit   clr;
    prev = 1'b0; clr = 1'b0;
    o_cap = 48'h0; o_low = 0; o_rises = 0; o_dones = 0; o_bad = 0; o_ones_hi = 0; o_got = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (clr) begin
        start = 1'b0;
        clr   = 1'b0;
      end
      if (m_sck && !prev) begin
        o_cap = {o_cap[46:0], m_sdo};
        o_rises++;
        if (o_rises == disturb_rise) begin
          start = 1'b1;
          sd0   = 8'h00;
          clr   = 1'b1;
        end
        if (o_rises == stop_rise) return;
      end
      prev = m_sck;
      if (!m_cs_n) o_low++;
      if (m_busy !== !m_cs_n) o_bad++;
      if (m_cs_n && m_sck) o_bad++;
      if (m_sck && m_sdo) o_ones_hi++;
      if (m_done) begin
        o_dones++;
        o_got = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic load(input logic [47:0] d);
    {sd0, sd1, sd2, sd3, sd4, sd5} = d;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel1 = 1'b0;
    load(48'hA53CFF00817E);

    // Reset held 3 cycles, then idle with no start
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outs", 64'({m_cs_n, m_sck, m_sdo, m_busy, m_done}), 64'(5'b10000));
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outs", 64'({m_cs_n, m_sck, m_sdo, m_busy, m_done}), 64'(5'b10000));
    end

    // Basic frame, CLK_DIV=2
    start = 1'b1; tick(); start = 1'b0;
    watch(400, -1, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    check("f1_done_seen", 64'(got_done), 64'(1));
    check("f1_data", 64'(cap), 64'(48'hA53CFF00817E));
    check("f1_cs_low", 64'(low), 64'(196));
    check("f1_rises", 64'(rises), 64'(48));
    check("f1_dones", 64'(dones), 64'(1));
    check("f1_sck_busy", 64'(bad), 64'(0));
    tick();
    check("f1_after_done", 64'({m_cs_n, m_sck, m_busy, m_done}), 64'(4'b1000));

    // Re-pulsed start and changed sd0 mid-frame must not affect anything
    tick();
    start = 1'b1; tick(); start = 1'b0;
    watch(400, 10, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    check("f2_done_seen", 64'(got_done), 64'(1));
    check("f2_data", 64'(cap), 64'(48'hA53CFF00817E));
    check("f2_cs_low", 64'(low), 64'(196));
    check("f2_sck_busy", 64'(bad), 64'(0));
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!m_cs_n || m_done || m_busy) idle_bad++;
    end
    check("f2_no_second_frame", 64'(idle_bad), 64'(0));
    sd0 = 8'hA5;

    // Start held high: back-to-back frames with a one-cycle cs_n gap
    start = 1'b1; tick();
    watch(400, -1, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    check("b2b_a_done", 64'(got_done), 64'(1));
    check("b2b_a_data", 64'(cap), 64'(48'hA53CFF00817E));
    check("b2b_a_cs_low", 64'(low), 64'(196));
    tick();
    check("b2b_gap_one_cycle", 64'({m_cs_n, m_busy}), 64'(2'b01));
    watch(400, -1, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    start = 1'b0;
    check("b2b_b_done", 64'(got_done), 64'(1));
    check("b2b_b_data", 64'(cap), 64'(48'hA53CFF00817E));
    check("b2b_b_cs_low", 64'(low), 64'(196));
    check("b2b_b_dones", 64'(dones), 64'(1));
    tick();
    check("b2b_stops", 64'({m_cs_n, m_busy, m_done}), 64'(3'b100));

    // Reset after the 20th sck rise aborts without done
    tick();
    start = 1'b1; tick(); start = 1'b0;
    watch(400, -1, 20, cap, low, rises, dones, bad, ones_hi, got_done);
    check("abort_reached_20", 64'(rises), 64'(20));
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_outs", 64'({m_cs_n, m_sck, m_busy, m_done}), 64'(4'b1000));
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m_cs_n || m_done || m_busy) idle_bad++;
    end
    check("abort_no_done", 64'(idle_bad), 64'(0));
    load(48'h123456789ABC);
    start = 1'b1; tick(); start = 1'b0;
    watch(400, -1, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    check("post_abort_done", 64'(got_done), 64'(1));
    check("post_abort_data", 64'(cap), 64'(48'h123456789ABC));
    check("post_abort_rises", 64'(rises), 64'(48));

    // CLK_DIV=1, single LSB set
    tick();
    sel1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (m_cs_n && !m_busy) break;
      tick();
    end
    load(48'h000000000001);
    start = 1'b1; tick(); start = 1'b0;
    watch(200, -1, -1, cap, low, rises, dones, bad, ones_hi, got_done);
    check("div1_done_seen", 64'(got_done), 64'(1));
    check("div1_data", 64'(cap), 64'(48'h000000000001));
    check("div1_cs_low", 64'(low), 64'(98));
    check("div1_rises", 64'(rises), 64'(48));
    check("div1_sdo_hi_phases", 64'(ones_hi), 64'(1));
    check("div1_sck_busy", 64'(bad), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
